// File: rtl/led_scan_capture.sv
// Passive receiver for a multiplexed seven-segment scan bus: rebuilds the per-digit
// segment patterns and publishes a coherent frame once every digit has been captured.
module led_scan_capture #(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_W          = 7,
    parameter int ACTIVE_LOW     = 1,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [SEG_W-1:0]              ledSegments_i,
    input  logic [NUM_DIGITS-1:0]         ledDigitSel_i,
    output logic [NUM_DIGITS*SEG_W-1:0]   digits_o,
    output logic                          frame_valid_o,
    output logic                          digits_changed_o,
    output logic                          scan_lost_o,
    output logic [7:0]                    multi_sel_cnt_o
);

    localparam int STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SEG_W-1:0]      SEG_IDLE  = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(STABLE_CYCLES - 2);
    localparam logic [TMO_W-1:0]      TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_CAPTURED
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
        return (v == TMO_MAX) ? v : v + 1'b1;
    endfunction

    logic [SEG_W-1:0]            seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [NUM_DIGITS-1:0]       sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [SEG_W-1:0]            prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]       prev_sel_q, prev_sel_d;
    state_t                      state_q, state_d;
    logic [STAB_W-1:0]           stab_q, stab_d;
    logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]       seen_q, seen_d;
    logic [NUM_DIGITS*SEG_W-1:0] digits_q, digits_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        changed_q, changed_d;
    logic                        lost_q, lost_d;
    logic [TMO_W-1:0]            tmo_q, tmo_d;
    logic [7:0]                  multi_q, multi_d;

    logic [SEG_W-1:0]      seg_n;
    logic [NUM_DIGITS-1:0] sel_n;
    logic                  sel_legal;
    logic                  sel_multi;
    logic                  prev_multi;
    logic                  sample_same;
    logic                  sel_changed;
    logic                  capture;
    logic                  commit;

    // Synchronized samples, normalized so that 1 means active
    assign seg_n       = (ACTIVE_LOW != 0) ? ~seg_s2_q : seg_s2_q;
    assign sel_n       = (ACTIVE_LOW != 0) ? ~sel_s2_q : sel_s2_q;
    assign sel_legal   = ($countones(sel_n) == 1);
    assign sel_multi   = ($countones(sel_n) >= 2);
    assign prev_multi  = ($countones(prev_sel_q) >= 2);
    assign sample_same = (sel_n == prev_sel_q) && (seg_n == prev_seg_q);
    assign sel_changed = (sel_n != prev_sel_q);
    assign commit      = &seen_q;

    always_comb begin
        seg_s1_d   = ledSegments_i;
        seg_s2_d   = seg_s1_q;
        sel_s1_d   = ledDigitSel_i;
        sel_s2_d   = sel_s1_q;
        prev_seg_d = seg_n;
        prev_sel_d = sel_n;
    end

    // Stability tracker: a digit is taken once per select assertion after a run of identical samples
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_legal) begin
                    state_d = ST_TRACK;
                    stab_d  = '0;
                end
            end
            ST_TRACK: begin
                if (!sample_same) begin
                    stab_d  = '0;
                    state_d = sel_legal ? ST_TRACK : ST_IDLE;
                end else if (stab_q == STAB_LAST) begin
                    capture = 1'b1;
                    stab_d  = '0;
                    state_d = ST_CAPTURED;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            ST_CAPTURED: begin
                if (sel_changed) begin
                    stab_d  = '0;
                    state_d = sel_legal ? ST_TRACK : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stab_d  = '0;
            end
        endcase
    end

    always_comb begin
        multi_d = (sel_multi && !prev_multi) ? sat_inc8(multi_q) : multi_q;

        frame_valid_d = commit;
        changed_d     = commit && (shadow_q != digits_q);
        digits_d      = commit ? shadow_q : digits_q;
        seen_d        = commit ? '0 : seen_q;
        shadow_d      = shadow_q;
        lost_d        = lost_q;
        tmo_d         = tmo_q;

        if (capture) begin
            tmo_d  = '0;
            lost_d = 1'b0;
        end else begin
            tmo_d = sat_inc_tmo(tmo_q);
            if (tmo_d == TMO_MAX) begin
                lost_d = 1'b1;
                seen_d = '0;
            end
        end

        // Applied after the commit clear so a capture in the commit cycle opens the next frame
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (capture && sel_n[k]) begin
                shadow_d[k*SEG_W +: SEG_W] = seg_n;
                seen_d[k]                  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            seg_s1_q      <= SEG_IDLE;
            seg_s2_q      <= SEG_IDLE;
            sel_s1_q      <= SEL_IDLE;
            sel_s2_q      <= SEL_IDLE;
            prev_seg_q    <= '0;
            prev_sel_q    <= '0;
            state_q       <= ST_IDLE;
            stab_q        <= '0;
            shadow_q      <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            lost_q        <= 1'b0;
            tmo_q         <= '0;
            multi_q       <= '0;
        end else begin
            seg_s1_q      <= seg_s1_d;
            seg_s2_q      <= seg_s2_d;
            sel_s1_q      <= sel_s1_d;
            sel_s2_q      <= sel_s2_d;
            prev_seg_q    <= prev_seg_d;
            prev_sel_q    <= prev_sel_d;
            state_q       <= state_d;
            stab_q        <= stab_d;
            shadow_q      <= shadow_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            lost_q        <= lost_d;
            tmo_q         <= tmo_d;
            multi_q       <= multi_d;
        end
    end

    assign digits_o         = digits_q;
    assign frame_valid_o    = frame_valid_q;
    assign digits_changed_o = changed_q;
    assign scan_lost_o      = lost_q;
    assign multi_sel_cnt_o  = multi_q;

endmodule

// File: doc/led_scan_capture.md
# led_scan_capture

Passive capture block for the multiplexed seven-segment bus driven by the LED digit display scanner. It samples the shared segment lines and the per-digit select lines and rebuilds the per-digit segment patterns, NUM_DIGITS × SEG_W bits in total. When every digit has been seen, it publishes one coherent frame. It sits at the receiving end of the display scan interface, for board self-check and for reading externally scanned displays.

## Interface
- NUM_DIGITS, 8, number of digit select lines and frame slots
- SEG_W, 7, segment lines per digit; bit 0 = segment a … bit 6 = segment g
- ACTIVE_LOW, 1, 1 = segment and select inputs are active low; 0 = active high
- STABLE_CYCLES, 16, consecutive identical synchronized samples required before a digit is captured (≥2)
- TIMEOUT_CYCLES, 65535, cycles without any capture before the scan is declared lost
- clk_i  in  1  single system clock; all logic on its rising edge
- rst_n_i  in  1  reset, synchronous and active-low
- ledSegments_i  in  SEG_W  raw segment lines (asynchronous)
- ledDigitSel_i  in  NUM_DIGITS  raw digit select lines (asynchronous)
- digits_o  out  NUM_DIGITS*SEG_W  committed frame; digit k at [k*SEG_W +: SEG_W], normalized so 1 = segment lit
- frame_valid_o  out  1  one-cycle pulse when digits_o is updated
- digits_changed_o  out  1  one-cycle pulse, coincident with frame_valid_o, when the new frame differs from the previous one
- scan_lost_o  out  1  level; 1 while no capture has occurred for TIMEOUT_CYCLES
- multi_sel_cnt_o  out  8  saturating count of entries into a multi-select condition

## Operation
- Both inputs pass through a 2-flop synchronizer. Polarity is then normalized per ACTIVE_LOW, so 1 = active.
- Select classification on the normalized value:
  - none: zero bits set
  - legal: exactly one bit set; that bit gives index k
  - multi: two or more bits set
- FSM states:
  - IDLE
    - Legal select → TRACK, with stab_cnt cleared.
    - Multi select → IDLE; multi_sel_cnt_o increments on each IDLE/TRACK/CAPTURED → multi transition.
  - TRACK
    - stab_cnt increments each cycle that the {sel, seg} sample equals the previous cycle's sample.
    - Any difference reloads stab_cnt to 0. If the new select is still legal, stay in TRACK; otherwise go to IDLE.
    - When stab_cnt reaches STABLE_CYCLES-1 (STABLE_CYCLES identical samples), write seg to shadow slot k, set seen[k], and go to CAPTURED.
  - CAPTURED
    - Hold while select is unchanged. Segment changes are ignored, so a digit is captured at most once per select assertion.
    - Select change to another legal one-hot → TRACK.
    - None → IDLE.
    - Multi → IDLE, incrementing the counter.
- Frame commit: in the cycle after seen becomes all ones, copy shadow → digits_o, pulse frame_valid_o, pulse digits_changed_o if shadow ≠ old digits_o, and clear seen.
- Re-capture of an already-seen digit before the frame completes overwrites its shadow slot. seen is unchanged.
- Timeout counter:
  - Cleared on every capture.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: scan_lost_o = 1 and seen is cleared; shadow is kept.
  - scan_lost_o returns to 0 in the cycle after the next capture.
- multi_sel_cnt_o saturates at 255.

## Timing
- Reset values: digits_o = 0, frame_valid_o = 0, digits_changed_o = 0, scan_lost_o = 0, multi_sel_cnt_o = 0, FSM = IDLE, seen = 0, shadow = 0, stab_cnt = 0, timeout = 0, synchronizers = inactive level.
- Input → synchronized sample latency: 2 cycles.
- A select/segment pair held steady from raw cycle t is captured on edge t+2+STABLE_CYCLES-1.
- The last digit's capture at edge c gives frame_valid_o high for exactly cycle c+1.
- Capture and timeout in the same cycle: the capture wins, the timeout counter clears, and scan_lost_o stays or becomes 0.
- A capture that completes seen in the commit cycle itself starts the next frame. The clear of seen applies only to bits set before that capture.
- Reset asserted mid-frame discards shadow and seen. The next frame requires all NUM_DIGITS digits again.

## Test plan
- Scan the 8 digits in order, each select held 40 cycles, with patterns 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07 driven inverted (ACTIVE_LOW=1). Expected: one frame_valid_o pulse 1 cycle after digit 7's capture, digits_o holding the normalized patterns, and digits_changed_o = 1.
- Repeat the identical scan. Expected: frame_valid_o pulses and digits_changed_o stays 0.
- Hold digit 3 for only STABLE_CYCLES-2 cycles per pass, other digits normal. Expected: no frame_valid_o pulse ever.
- Assert digit selects 2 and 5 together for 30 cycles, 300 times. Expected: no captures during those windows and multi_sel_cnt_o = 255 (saturated).
- Stop the scan for TIMEOUT_CYCLES+10 cycles. Expected: scan_lost_o = 1 at cycle TIMEOUT_CYCLES. After resuming, scan_lost_o = 0 after the first capture, and a full 8-digit pass is needed before frame_valid_o.
- Pulse rst_n_i low for 1 cycle after 5 digits are captured. Expected: all outputs return to reset values, and the next frame_valid_o comes only after 8 new captures.
